// File: rtl/fnd_bcd_scan_driver.sv
// ---------------------------------------------------------------------------
// fnd_bcd_scan_driver
//
// Purpose:
//   Sequential front end for a 4-digit common-anode FND.
//   - Takes a binary value and a load strobe.
//   - Converts the value to four BCD digits with an iterative shift-add-3
//     datapath, one bit per clock.
//   - Holds the converted digits in a display register.
//   - Time-multiplexes the digits onto the shared segment and anode lines.
//
// Ports:
//   i_clk      system clock
//   i_reset_p  synchronous, active-high reset
//   i_value    binary value to show; values above 9999 saturate to 9999
//   i_load     single-cycle request; accepted only while o_busy = 0
//   i_dp_in    decimal-point enables; bit i lights the dp of digit i
//   o_busy     conversion in progress
//   o_ovf      the last accepted value exceeded 9999
//   o_seg      active-low segments, bit7 = dp ... bit0 = a
//   o_an       active-low anodes, bit0 = rightmost (ones) digit
//
// Parameters:
//   SCAN_DIV   clocks per digit slot (>= 2)
//
// Build option:
//   FND_LEADING_ZERO_BLANK_EN
//     When defined, digits 1..3 are blanked if they and every higher digit
//     are zero. The decimal point of a blanked digit still follows i_dp_in.
// ---------------------------------------------------------------------------
module fnd_bcd_scan_driver #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset_p,
  input  logic [13:0] i_value,
  input  logic        i_load,
  input  logic [3:0]  i_dp_in,
  output logic        o_busy,
  output logic        o_ovf,
  output logic [7:0]  o_seg,
  output logic [3:0]  o_an
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  localparam int PRESC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

  logic [0:0]         r_state;
  logic [13:0]        r_shiftReg;
  logic [15:0]        r_bcdAcc;
  logic [3:0]         r_bitCnt;
  logic [3:0]         r_dpShadow;
  logic [15:0]        r_digits;
  logic [3:0]         r_dispDp;
  logic               r_busy;
  logic               r_ovf;
  logic [PRESC_W-1:0] r_presc;
  logic [1:0]         r_scanIdx;
  logic [7:0]         r_seg;
  logic [3:0]         r_an;

  logic [15:0]        w_bcdAdj;
  logic [29:0]        w_shiftNext;
  logic [3:0]         w_digit;
  logic               w_dp;
  logic               w_blank;
  logic [3:0]         w_anNext;

  // Returns the low seven bits of the active-low segment pattern for a
  // digit. Bit 7 (dp) is handled separately. Any nibble above 9 is dark.
  function automatic logic [6:0] segOf(input logic [3:0] d);
    case (d)
      4'd0:    segOf = 7'h40;
      4'd1:    segOf = 7'h79;
      4'd2:    segOf = 7'h24;
      4'd3:    segOf = 7'h30;
      4'd4:    segOf = 7'h19;
      4'd5:    segOf = 7'h12;
      4'd6:    segOf = 7'h02;
      4'd7:    segOf = 7'h78;
      4'd8:    segOf = 7'h00;
      4'd9:    segOf = 7'h10;
      default: segOf = 7'h7F;
    endcase
  endfunction

  // Shift-add-3 correction step.
  // Every BCD nibble that is 5 or more gets 3 added before the next shift,
  // so a doubled nibble carries correctly into the next decade.
  always_comb begin
    w_bcdAdj = r_bcdAcc;
    for (int i = 0; i < 4; i++) begin
      if (r_bcdAcc[4*i +: 4] >= 4'd5) begin
        w_bcdAdj[4*i +: 4] = r_bcdAcc[4*i +: 4] + 4'd3;
      end
    end
  end

  // The accumulator and the binary shift register behave as one long word
  // that moves left one bit per iteration.
  assign w_shiftNext = {w_bcdAdj, r_shiftReg} << 1;

  // Conversion FSM.
  // IDLE accepts a load, saturating out-of-range values to 9999.
  // CONV runs 14 shift iterations and then commits the result. The display
  // registers are written only at the commit edge, so the scan never shows
  // a half-converted value. A load while busy is simply not looked at.
  always_ff @(posedge i_clk) begin
    if (i_reset_p) begin
      r_state    <= ST_IDLE;
      r_shiftReg <= '0;
      r_bcdAcc   <= '0;
      r_bitCnt   <= '0;
      r_dpShadow <= '0;
      r_digits   <= '0;
      r_dispDp   <= '0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            if (i_value > 14'd9999) begin
              r_shiftReg <= 14'd9999;
              r_ovf      <= 1'b1;
            end else begin
              r_shiftReg <= i_value;
              r_ovf      <= 1'b0;
            end
            r_dpShadow <= i_dp_in;
            r_bcdAcc   <= '0;
            r_bitCnt   <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (r_bitCnt == 4'd14) begin
            r_digits <= r_bcdAcc;
            r_dispDp <= r_dpShadow;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end else begin
            {r_bcdAcc, r_shiftReg} <= w_shiftNext;
            r_bitCnt <= r_bitCnt + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Scan timing.
  // The prescaler free-runs 0..SCAN_DIV-1. Its last count advances the
  // digit index, which wraps 3 -> 0. The scan runs regardless of the FSM.
  always_ff @(posedge i_clk) begin
    if (i_reset_p) begin
      r_presc   <= '0;
      r_scanIdx <= '0;
    end else begin
      if (r_presc == PRESC_LAST) begin
        r_presc   <= '0;
        r_scanIdx <= r_scanIdx + 2'd1;
      end else begin
        r_presc <= r_presc + PRESC_W'(1);
      end
    end
  end

  // Select the digit, dp and anode for the active slot.
  // It also decides whether the slot is a leading zero to blank.
  always_comb begin
    w_digit  = r_digits[3:0];
    w_dp     = r_dispDp[0];
    w_anNext = 4'b1110;
    w_blank  = 1'b0;
    case (r_scanIdx)
      2'd0: begin
        w_digit  = r_digits[3:0];
        w_dp     = r_dispDp[0];
        w_anNext = 4'b1110;
      end
      2'd1: begin
        w_digit  = r_digits[7:4];
        w_dp     = r_dispDp[1];
        w_anNext = 4'b1101;
`ifdef FND_LEADING_ZERO_BLANK_EN
        w_blank  = (r_digits[15:4] == 12'd0);
`endif
      end
      2'd2: begin
        w_digit  = r_digits[11:8];
        w_dp     = r_dispDp[2];
        w_anNext = 4'b1011;
`ifdef FND_LEADING_ZERO_BLANK_EN
        w_blank  = (r_digits[15:8] == 8'd0);
`endif
      end
      default: begin
        w_digit  = r_digits[15:12];
        w_dp     = r_dispDp[3];
        w_anNext = 4'b0111;
`ifdef FND_LEADING_ZERO_BLANK_EN
        w_blank  = (r_digits[15:12] == 4'd0);
`endif
      end
    endcase
  end

  // Registered pin drivers.
  // Registering the outputs keeps the pins glitch-free. They lag the scan
  // index and the display register by one clock.
  always_ff @(posedge i_clk) begin
    if (i_reset_p) begin
      r_seg <= 8'hFF;
      r_an  <= 4'b1111;
    end else begin
      r_seg <= {~w_dp, (w_blank ? 7'h7F : segOf(w_digit))};
      r_an  <= w_anNext;
    end
  end

  assign o_busy = r_busy;
  assign o_ovf  = r_ovf;
  assign o_seg  = r_seg;
  assign o_an   = r_an;

endmodule

// File: tb/tb_fnd_bcd_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_fnd_bcd_scan_driver
//
// Self-checking bench for fnd_bcd_scan_driver, run with SCAN_DIV = 4.
// Each vector is loaded, its expected result is queued, and the observed
// busy length, ovf flag and one full scan frame are compared against the
// queued expectation. Hand-written sequences cover:
//   - the reset / scan start-up behaviour,
//   - loads issued while busy,
//   - a reset that lands in the middle of a conversion.
// ---------------------------------------------------------------------------
module tb_fnd_bcd_scan_driver;

  localparam int SCAN_DIV = 4;

`ifdef FND_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ   = 8'hFF;
  localparam logic [7:0] LZDP = 8'h7F;
`else
  localparam logic [7:0] LZ   = 8'hC0;
  localparam logic [7:0] LZDP = 8'h40;
`endif

  typedef struct {
    logic [13:0]     value;
    logic [3:0]      dp;
    logic            expOvf;
    logic [3:0][7:0] expSeg;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetP;
  logic [13:0] value;
  logic        load;
  logic [3:0]  dpIn;
  logic        busy;
  logic        ovf;
  logic [7:0]  seg;
  logic [3:0]  an;

  int   checks   = 0;
  int   failures = 0;
  int   obsBusyCycles;
  logic obsBusyAfter;

  vec_t vecs[9];
  vec_t expQ[$];

  fnd_bcd_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .i_clk    (clk),
    .i_reset_p(resetP),
    .i_value  (value),
    .i_load   (load),
    .i_dp_in  (dpIn),
    .o_busy   (busy),
    .o_ovf    (ovf),
    .o_seg    (seg),
    .o_an     (an)
  );

  // 100 MHz-style clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Global time limit so a stuck design still produces a summary line.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Loads one vector and queues its expectation.
  // It then measures how long busy stays high. With inject set, ignored
  // load requests are raised at the E2 edge and at the commit edge E15.
  task automatic applyStimulus(input vec_t v, input bit inject);
    int n;
    value = v.value;
    dpIn  = v.dp;
    load  = 1'b1;
    stepCycle();
    load  = 1'b0;
    expQ.push_back(v);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (inject && (n == 2 || n == 15)) begin
        load  = 1'b1;
        value = 14'd7;
        dpIn  = 4'b1111;
      end else begin
        load = 1'b0;
      end
      stepCycle();
    end
    load          = 1'b0;
    obsBusyCycles = n;
    stepCycle();
    obsBusyAfter  = busy;
  endtask

  // Watches 16 consecutive cycles (one frame at SCAN_DIV = 4).
  // Each observed segment value is filed under the digit its anode selects.
  task automatic checkFrame(input logic [3:0][7:0] expSeg, input string tag);
    logic [7:0] seen[4];
    bit         got[4];
    bit         bad[4];
    bit         badAn;
    int         k;
    badAn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen[i] = 8'hxx;
      got[i]  = 1'b0;
      bad[i]  = 1'b0;
    end
    for (int c = 0; c < 16; c++) begin
      case (an)
        4'b1110: k = 0;
        4'b1101: k = 1;
        4'b1011: k = 2;
        4'b0111: k = 3;
        default: k = -1;
      endcase
      if (k < 0) begin
        badAn = 1'b1;
      end else begin
        got[k] = 1'b1;
        if (seg !== expSeg[k]) begin
          bad[k]  = 1'b1;
          seen[k] = seg;
        end else if (!bad[k]) begin
          seen[k] = seg;
        end
      end
      if (c < 15) stepCycle();
    end
    checkVal({tag, "_an_valid"}, {31'd0, badAn}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkVal($sformatf("%s_seg_digit%0d", tag, i), {24'd0, (got[i] ? seen[i] : 8'hxx)}, {24'd0, expSeg[i]});
    end
  endtask

  // Pops the oldest expectation and compares it against the observations.
  task automatic checkOutput();
    vec_t  e;
    string tag;
    e   = expQ.pop_front();
    tag = $sformatf("v%0d", e.value);
    checkVal({tag, "_busy_cycles"}, obsBusyCycles, 32'd15);
    checkVal({tag, "_busy_after"}, {31'd0, obsBusyAfter}, 32'd0);
    checkVal({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.expOvf});
    checkFrame(e.expSeg, tag);
  endtask

  initial begin
    vec_t v;

    vecs[0] = '{14'd1234,  4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = '{14'd12,    4'b0100, 1'b0, {LZ,    LZDP,  8'hF9, 8'hA4}};
    vecs[2] = '{14'd12000, 4'b0000, 1'b1, {8'h90, 8'h90, 8'h90, 8'h90}};
    vecs[3] = '{14'd5,     4'b0000, 1'b0, {LZ,    LZ,    LZ,    8'h92}};
    vecs[4] = '{14'd9999,  4'b1010, 1'b0, {8'h10, 8'h90, 8'h10, 8'h90}};
    vecs[5] = '{14'd10000, 4'b0000, 1'b1, {8'h90, 8'h90, 8'h90, 8'h90}};
    vecs[6] = '{14'd0,     4'b0001, 1'b0, {LZ,    LZ,    LZ,    8'h40}};
    vecs[7] = '{14'd305,   4'b0000, 1'b0, {LZ,    8'hB0, 8'hC0, 8'h92}};
    vecs[8] = '{14'd16383, 4'b0000, 1'b1, {8'h90, 8'h90, 8'h90, 8'h90}};

    resetP = 1'b1;
    load   = 1'b0;
    value  = '0;
    dpIn   = '0;

    // Reset and scan start-up.
    repeat (3) stepCycle();
    checkVal("reset_seg", {24'd0, seg}, 32'hFF);
    checkVal("reset_an", {28'd0, an}, 32'hF);
    checkVal("reset_busy", {31'd0, busy}, 32'd0);
    checkVal("reset_ovf", {31'd0, ovf}, 32'd0);
    resetP = 1'b0;
    stepCycle();
    checkVal("first_an", {28'd0, an}, 32'hE);
    checkVal("first_seg", {24'd0, seg}, 32'hC0);
    repeat (3) stepCycle();
    checkVal("slot0_last_an", {28'd0, an}, 32'hE);
    stepCycle();
    checkVal("slot1_an", {28'd0, an}, 32'hD);
    repeat (4) stepCycle();
    checkVal("slot2_an", {28'd0, an}, 32'hB);
    repeat (4) stepCycle();
    checkVal("slot3_an", {28'd0, an}, 32'h7);
    repeat (4) stepCycle();
    checkVal("wrap_an", {28'd0, an}, 32'hE);

    // Table-driven conversions.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], 1'b0);
      checkOutput();
    end

    // Loads while busy, including on the commit edge, must be ignored.
    v = '{14'd5, 4'b0000, 1'b0, {LZ, LZ, LZ, 8'h92}};
    applyStimulus(v, 1'b1);
    checkOutput();

    // Reset in the middle of a conversion.
    value = 14'd9999;
    dpIn  = 4'b1111;
    load  = 1'b1;
    stepCycle();
    load  = 1'b0;
    repeat (4) stepCycle();
    checkVal("midconv_busy", {31'd0, busy}, 32'd1);
    resetP = 1'b1;
    stepCycle();
    checkVal("abort_busy", {31'd0, busy}, 32'd0);
    checkVal("abort_ovf", {31'd0, ovf}, 32'd0);
    checkVal("abort_seg", {24'd0, seg}, 32'hFF);
    checkVal("abort_an", {28'd0, an}, 32'hF);
    resetP = 1'b0;
    stepCycle();
    checkVal("abort_release_an", {28'd0, an}, 32'hE);
    checkVal("abort_release_seg", {24'd0, seg}, 32'hC0);
    checkFrame({LZ, LZ, LZ, 8'hC0}, "abort_frame");
    stepCycle();
    checkVal("abort_stays_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
